// File: rtl/n64_joybus_pkg.sv
// n64_joybus_pkg: shared definitions for the joybus receiver and transmitter.
//   - command codes for the console-to-controller command byte
//   - receiver state encoding
//   - frame_bits(): number of bits a command frame carries (0 = unknown command)
//   - crc8_step(): one MSB-first, non-reflected, augmented CRC-8 shift
package n64_joybus_pkg;

  localparam logic [7:0] CMD_INFO   = 8'h00;
  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_WRITE  = 8'h03;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DRAIN = 3'd4
  } rx_state_e;

  function automatic int frame_bits(input logic [7:0] cmd, input int max_bytes);
    int bits;
    case (cmd)
      CMD_INFO, CMD_STATUS, CMD_RESET: bits = 8;
      CMD_READ:                        bits = 24;
      CMD_WRITE:                       bits = 24 + 8 * max_bytes;
      default:                         bits = 0;
    endcase
    return bits;
  endfunction

  // Augmented form: the message bit enters at the LSB and the polynomial is
  // applied when the bit leaving the MSB is set. Eight trailing zero bits
  // turn the remainder into the final CRC.
  function automatic logic [7:0] crc8_step(input logic [7:0] rem,
                                           input logic       bit_in,
                                           input logic [7:0] poly);
    return {rem[6:0], bit_in} ^ (rem[7] ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/n64_crc8_serial.sv
// n64_crc8_serial: bit-serial CRC-8 remainder register, shared by the joybus
// receiver and transmitter.
//   clk_i     clock
//   reset_i   asynchronous active-high reset (remainder -> 0)
//   clear_i   synchronous clear to 0 (start of frame), wins over enable_i
//   enable_i  shift bit_in_i into the remainder this cycle
//   bit_in_i  message (or augmentation zero) bit
//   rem_o     current remainder
module n64_crc8_serial
  import n64_joybus_pkg::*;
#(
  parameter logic [7:0] CRC_POLY = 8'h85
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       enable_i,
  input  logic       bit_in_i,
  output logic [7:0] rem_o
);

  logic [7:0] rem_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rem_q <= 8'h00;
    end else if (clear_i) begin
      rem_q <= 8'h00;
    end else if (enable_i) begin
      rem_q <= crc8_step(rem_q, bit_in_i, CRC_POLY);
    end
  end

  assign rem_o = rem_q;

endmodule

// File: rtl/n64_cmd_rx.sv
// n64_cmd_rx: controller-side receiver for console-to-controller joybus frames.
// Oversamples the line, decodes pulse-width bit cells, parses command, address
// and WRITE payload, and computes the payload CRC in line.
//   clk_i          sampling clock (CLK_PER_US cycles per microsecond)
//   reset_i        asynchronous active-high reset
//   tx_busy_i      our transmitter owns the line; receiver stays idle / aborts
//   data_rx_i      raw joybus line, idle high, asynchronous
//   cmd_o          last command byte (shifted in bitwise)
//   address_o      16-bit address field of READ/WRITE
//   data_byte_o    payload byte, qualified by data_valid_o
//   data_valid_o   1-cycle strobe per completed payload byte
//   data_idx_o     index of data_byte_o within the payload
//   crc_o          payload CRC of the last WRITE
//   frame_done_o   1-cycle pulse, frame ended with a valid stop bit
//   frame_err_o    1-cycle pulse, frame aborted
//   busy_o         frame in progress
//
// state    | meaning
// ST_IDLE  | line idle, waiting for the first falling edge
// ST_LOW   | inside the low phase of a bit cell
// ST_HIGH  | inside the high phase of a bit cell
// ST_STOP  | all bits received, inside the stop-bit low phase
// ST_DRAIN | unknown command, waiting for the line to go quiet
module n64_cmd_rx
  import n64_joybus_pkg::*;
#(
  parameter int         CLK_PER_US     = 4,
  parameter int         MAX_DATA_BYTES = 32,
  parameter int         IDLE_US        = 8,
  parameter logic [7:0] CRC_POLY       = 8'h85,
  localparam int        IDX_W          = (MAX_DATA_BYTES > 1) ? $clog2(MAX_DATA_BYTES) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             tx_busy_i,
  input  logic             data_rx_i,
  output logic [7:0]       cmd_o,
  output logic [15:0]      address_o,
  output logic [7:0]       data_byte_o,
  output logic             data_valid_o,
  output logic [IDX_W-1:0] data_idx_o,
  output logic [7:0]       crc_o,
  output logic             frame_done_o,
  output logic             frame_err_o,
  output logic             busy_o
);

  localparam int IDLE_CYC = IDLE_US * CLK_PER_US;
  localparam int CNT_MAX  = (IDLE_CYC > 4 * CLK_PER_US) ? IDLE_CYC : 4 * CLK_PER_US;
  // Room to exceed CNT_MAX by one before saturating, so "> 4 us" is visible.
  localparam int CNT_W    = $clog2(CNT_MAX + 2);
  localparam int MAX_BITS = 24 + 8 * MAX_DATA_BYTES;
  localparam int BIT_W    = $clog2(MAX_BITS + 1);

  localparam logic [CNT_W-1:0] GLITCH_LIM = CNT_W'(CLK_PER_US / 2);
  localparam logic [CNT_W-1:0] ONE_LIM    = CNT_W'(2 * CLK_PER_US);
  localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(4 * CLK_PER_US);
  localparam logic [CNT_W-1:0] IDLE_LIM   = CNT_W'(IDLE_CYC);

  rx_state_e        state_q, state_d;
  logic [1:0]       sync_q;
  logic             line_q;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d, high_cnt_q, high_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, exp_bits;
  logic [IDX_W-1:0] byte_cnt_q, data_idx_q;
  logic [7:0]       cmd_q, cmd_shift, data_byte_q, crc_q, crc_rem;
  logic [15:0]      addr_q;
  logic [6:0]       data_sr_q;
  logic [3:0]       aug_cnt_q;
  logic             data_valid_q, done_q, err_q;
  logic             line, rise, fall;
  logic             start, bit_stb, bit_val, done_d, err_d;
  logic             in_addr, in_payload, byte_end, last_bit, crc_en, crc_bit;

  assign line = sync_q[1];
  assign rise = line & ~line_q;
  assign fall = ~line & line_q;

  assign low_cnt_d  = line ? '0 : ((low_cnt_q == '1) ? low_cnt_q : low_cnt_q + 1'b1);
  assign high_cnt_d = line ? ((high_cnt_q == '1) ? high_cnt_q : high_cnt_q + 1'b1) : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q     <= 2'b11;
      line_q     <= 1'b1;
      low_cnt_q  <= '0;
      high_cnt_q <= '0;
      state_q    <= ST_IDLE;
    end else begin
      sync_q     <= {sync_q[0], data_rx_i};
      line_q     <= line;
      low_cnt_q  <= low_cnt_d;
      high_cnt_q <= high_cnt_d;
      state_q    <= state_d;
    end
  end

  assign cmd_shift = {cmd_q[6:0], bit_val};
  assign exp_bits  = BIT_W'(frame_bits(cmd_q, MAX_DATA_BYTES));

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    bit_stb = 1'b0;
    bit_val = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fall && !tx_busy_i) begin
          start   = 1'b1;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (rise) begin
          if (low_cnt_q < GLITCH_LIM || low_cnt_q > LONG_LIM) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            bit_stb = 1'b1;
            bit_val = low_cnt_q < ONE_LIM;
            state_d = ST_HIGH;
            // The command is known as soon as its last bit decodes.
            if (bit_cnt_q == BIT_W'(7) && frame_bits(cmd_shift, MAX_DATA_BYTES) == 0) begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_HIGH: begin
        if (high_cnt_q >= IDLE_LIM) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (fall) begin
          state_d = (bit_cnt_q == exp_bits) ? ST_STOP : ST_LOW;
        end
      end
      ST_STOP: begin
        if (rise) begin
          done_d  = low_cnt_q < ONE_LIM;
          err_d   = !(low_cnt_q < ONE_LIM);
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (high_cnt_q >= IDLE_LIM) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Our own transmitter taking the line kills any frame in progress.
    if (state_q != ST_IDLE && tx_busy_i) begin
      state_d = ST_IDLE;
      bit_stb = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  assign in_addr    = (bit_cnt_q >= BIT_W'(8)) && (bit_cnt_q < BIT_W'(24));
  assign in_payload = bit_cnt_q >= BIT_W'(24);
  assign byte_end   = bit_cnt_q[2:0] == 3'd7;
  assign last_bit   = bit_cnt_q == BIT_W'(MAX_BITS - 1);
  assign crc_en     = (bit_stb && in_payload) || (aug_cnt_q != 4'd0);
  assign crc_bit    = bit_stb && bit_val;

  n64_crc8_serial #(.CRC_POLY(CRC_POLY)) u_crc (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (start),
    .enable_i (crc_en),
    .bit_in_i (crc_bit),
    .rem_o    (crc_rem)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      cmd_q        <= 8'hFE;
      addr_q       <= '0;
      data_sr_q    <= '0;
      data_byte_q  <= '0;
      data_valid_q <= 1'b0;
      data_idx_q   <= '0;
      crc_q        <= '0;
      aug_cnt_q    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      done_q       <= done_d;
      err_q        <= err_d;
      if (start) begin
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
      end else if (bit_stb) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        if (in_payload) begin
          data_sr_q <= {data_sr_q[5:0], bit_val};
          if (byte_end) begin
            data_byte_q  <= {data_sr_q, bit_val};
            data_valid_q <= 1'b1;
            data_idx_q   <= byte_cnt_q;
            byte_cnt_q   <= (byte_cnt_q == IDX_W'(MAX_DATA_BYTES - 1)) ? '0 : byte_cnt_q + 1'b1;
          end
        end else if (in_addr) begin
          addr_q <= {addr_q[14:0], bit_val};
        end else begin
          cmd_q <= cmd_shift;
        end
      end
      // Augmentation: eight zero shifts after the last payload bit; the last
      // shift's result is captured directly so crc_o is ready by the stop bit.
      if (start || err_d) begin
        aug_cnt_q <= '0;
      end else if (bit_stb && last_bit) begin
        aug_cnt_q <= 4'd8;
      end else if (aug_cnt_q != 4'd0) begin
        aug_cnt_q <= aug_cnt_q - 1'b1;
      end
      if (aug_cnt_q == 4'd1) begin
        crc_q <= crc8_step(crc_rem, 1'b0, CRC_POLY);
      end
    end
  end

  assign cmd_o        = cmd_q;
  assign address_o    = addr_q;
  assign data_byte_o  = data_byte_q;
  assign data_valid_o = data_valid_q;
  assign data_idx_o   = data_idx_q;
  assign crc_o        = crc_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;
  assign busy_o       = state_q != ST_IDLE;

endmodule

// File: tb/tb_n64_cmd_rx.sv
module tb_n64_cmd_rx;

  localparam logic [7:0] POLY = 8'h85;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_busy = 1'b0;
  logic        data_rx = 1'b1;
  logic [7:0]  cmd, data_byte, crc;
  logic [15:0] address;
  logic        data_valid, frame_done, frame_err, busy;
  logic [4:0]  data_idx;

  n64_cmd_rx dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .tx_busy_i    (tx_busy),
    .data_rx_i    (data_rx),
    .cmd_o        (cmd),
    .address_o    (address),
    .data_byte_o  (data_byte),
    .data_valid_o (data_valid),
    .data_idx_o   (data_idx),
    .crc_o        (crc),
    .frame_done_o (frame_done),
    .frame_err_o  (frame_err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int          n_asserts = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          n_err = 0;
  bit          busy_seen = 0;
  logic [7:0]  vq_byte[$];
  logic [4:0]  vq_idx[$];
  logic [7:0]  pl[32];

  always @(negedge clk) begin
    if (frame_done === 1'b1) n_done++;
    if (frame_err === 1'b1) n_err++;
    if (busy === 1'b1) busy_seen = 1;
    if (data_valid === 1'b1) begin
      vq_byte.push_back(data_byte);
      vq_idx.push_back(data_idx);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    data_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit_t(input logic b, input int lo, input int hi);
    hold(1'b0, lo);
    hold(1'b1, hi);
  endtask

  // Random but legal cell timing; a 0 keeps a short high so stop follows soon.
  task automatic send_bit(input logic b);
    int lo, hi;
    if (b) begin
      lo = $urandom_range(6, 2);
      hi = $urandom_range(12, 8);
    end else begin
      lo = $urandom_range(16, 9);
      hi = $urandom_range(6, 4);
    end
    send_bit_t(b, lo, hi);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_stop();
    hold(1'b0, 4);
    hold(1'b1, 40);
  endtask

  task automatic send_write(input logic [15:0] a);
    send_byte(8'h03);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    for (int i = 0; i < 32; i++) send_byte(pl[i]);
    send_stop();
  endtask

  // Direct-form polynomial division of the 256 payload bits.
  function automatic logic [7:0] crc_ref();
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < 32; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ pl[i][b];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ POLY;
      end
    end
    return c;
  endfunction

  task automatic expect_pulses(input string tag, input int d0, input int e0,
                               input int dn, input int en);
    chk({tag, "_done"}, n_done - d0, dn);
    chk({tag, "_err"}, n_err - e0, en);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic check_payload(input string tag);
    chk({tag, "_nvalid"}, vq_byte.size(), 32);
    if (vq_byte.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        chk({tag, "_idx"}, vq_idx[i], i);
        chk({tag, "_byte"}, vq_byte[i], pl[i]);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cmd"}, cmd, 8'hFE);
    chk({tag, "_addr"}, address, 16'h0000);
    chk({tag, "_dbyte"}, data_byte, 8'h00);
    chk({tag, "_dvalid"}, data_valid, 1'b0);
    chk({tag, "_didx"}, data_idx, 5'd0);
    chk({tag, "_crc"}, crc, 8'h00);
    chk({tag, "_done"}, frame_done, 1'b0);
    chk({tag, "_err"}, frame_err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int         d0, e0, nv;
    logic [7:0] c, crc_before;
    logic [15:0] a;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b0;
    hold(1'b1, 10);

    // STATUS
    d0 = n_done; e0 = n_err; vq_byte.delete(); vq_idx.delete();
    send_byte(8'h01);
    send_stop();
    chk("status_cmd", cmd, 8'h01);
    expect_pulses("status", d0, e0, 1, 0);
    chk("status_nvalid", vq_byte.size(), 0);

    // Cell-width boundaries: lows of 2 and 7 decode as 1, 8 and 16 as 0
    d0 = n_done; e0 = n_err;
    for (int i = 0; i < 8; i++) send_bit_t(1'b1, (i % 2 == 0) ? 2 : 7, 10);
    send_stop();
    chk("bound1_cmd", cmd, 8'hFF);
    expect_pulses("bound1", d0, e0, 1, 0);
    d0 = n_done; e0 = n_err;
    for (int i = 0; i < 8; i++) send_bit_t(1'b0, (i % 2 == 0) ? 8 : 16, 4);
    send_stop();
    chk("bound0_cmd", cmd, 8'h00);
    expect_pulses("bound0", d0, e0, 1, 0);

    // READ
    d0 = n_done; e0 = n_err; crc_before = crc;
    send_byte(8'h02);
    send_byte(8'h80);
    send_byte(8'h01);
    send_stop();
    chk("read_cmd", cmd, 8'h02);
    chk("read_addr", address, 16'h8001);
    chk("read_crc", crc, crc_before);
    expect_pulses("read", d0, e0, 1, 0);

    // WRITE of zeros
    for (int i = 0; i < 32; i++) pl[i] = 8'h00;
    d0 = n_done; e0 = n_err; vq_byte.delete(); vq_idx.delete();
    send_write(16'h1234);
    chk("wr0_addr", address, 16'h1234);
    chk("wr0_crc", crc, 8'h00);
    check_payload("wr0");
    expect_pulses("wr0", d0, e0, 1, 0);

    // WRITE of 0x00..0x1F
    for (int i = 0; i < 32; i++) pl[i] = 8'(i);
    d0 = n_done; e0 = n_err; vq_byte.delete(); vq_idx.delete();
    send_write(16'hC01B);
    chk("wrseq_crc", crc, crc_ref());
    check_payload("wrseq");
    expect_pulses("wrseq", d0, e0, 1, 0);

    // WRITE of random payload at a random address
    for (int i = 0; i < 32; i++) pl[i] = 8'($urandom_range(255, 0));
    a = 16'($urandom_range(16'hFFFF, 0));
    d0 = n_done; e0 = n_err; vq_byte.delete(); vq_idx.delete();
    send_write(a);
    chk("wrrnd_addr", address, a);
    chk("wrrnd_crc", crc, crc_ref());
    check_payload("wrrnd");
    expect_pulses("wrrnd", d0, e0, 1, 0);

    // Unknown commands drain until the line has been high for 8 us
    for (int k = 0; k < 2; k++) begin
      if (k == 0) c = 8'h42;
      else begin
        c = 8'h42;
        while (c == 8'h00 || c == 8'h01 || c == 8'h02 || c == 8'h03 || c == 8'hFF || c == 8'h42)
          c = 8'($urandom_range(255, 0));
      end
      d0 = n_done; e0 = n_err;
      send_byte(c);
      send_bit(1'b0);
      hold(1'b1, 18);
      chk("drain_early_err", n_err - e0, 0);
      chk("drain_busy", busy, 1'b1);
      hold(1'b1, 30);
      chk("drain_cmd", cmd, c);
      expect_pulses("drain", d0, e0, 0, 1);
    end
    d0 = n_done; e0 = n_err;
    send_byte(8'h00);
    send_stop();
    chk("after_drain_cmd", cmd, 8'h00);
    expect_pulses("after_drain", d0, e0, 1, 0);

    // One-cycle glitch mid-byte
    d0 = n_done; e0 = n_err;
    send_byte(8'h02);
    send_bit(1'b1);
    send_bit(1'b0);
    hold(1'b0, 1);
    hold(1'b1, 40);
    expect_pulses("glitch", d0, e0, 0, 1);

    // Line parked high mid-READ
    d0 = n_done; e0 = n_err;
    send_byte(8'h02);
    send_byte(8'h5A);
    send_bit(1'b0);
    hold(1'b1, 40);
    expect_pulses("timeout", d0, e0, 0, 1);

    // Low phase longer than 4 us
    d0 = n_done; e0 = n_err;
    send_bit(1'b0);
    send_bit(1'b1);
    hold(1'b0, 17);
    hold(1'b1, 40);
    expect_pulses("longlow", d0, e0, 0, 1);

    // Line activity while our transmitter is busy is ignored
    d0 = n_done; e0 = n_err;
    tx_busy = 1'b1;
    hold(1'b1, 2);
    busy_seen = 0;
    send_byte(8'h01);
    send_stop();
    chk("txbusy_seen", busy_seen, 1'b0);
    tx_busy = 1'b0;
    hold(1'b1, 5);
    expect_pulses("txbusy", d0, e0, 0, 0);

    // Transmitter grabbing the line mid-frame aborts it
    d0 = n_done; e0 = n_err;
    send_bit(1'b0);
    send_bit(1'b1);
    tx_busy = 1'b1;
    hold(1'b1, 4);
    tx_busy = 1'b0;
    hold(1'b1, 40);
    expect_pulses("txabort", d0, e0, 0, 1);

    // Reset during WRITE payload
    for (int i = 0; i < 32; i++) pl[i] = 8'($urandom_range(255, 0));
    d0 = n_done; e0 = n_err; vq_byte.delete(); vq_idx.delete();
    send_byte(8'h03);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(pl[0]);
    send_bit(pl[1][7]);
    send_bit(pl[1][6]);
    nv = vq_byte.size();
    chk("rstmid_nvalid", nv, 1);
    reset = 1'b1;
    data_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rstmid");
    reset = 1'b0;
    hold(1'b1, 40);
    chk("rstmid_nvalid_after", vq_byte.size(), nv);
    expect_pulses("rstmid", d0, e0, 0, 0);
    d0 = n_done; e0 = n_err;
    send_byte(8'hFF);
    send_stop();
    chk("post_rst_cmd", cmd, 8'hFF);
    expect_pulses("post_rst", d0, e0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/n64_cmd_rx.md
Name: n64_cmd_rx

Overview:
Controller-side receiver for console-to-controller N64 joybus frames. It runs on one oversampling clock, decodes pulse-width bit cells and parses the command byte. Depending on the command it then captures a 16-bit address and up to MAX_DATA_BYTES payload bytes, and runs the data CRC in line. A done or error pulse hands the frame to the controller transmitter. This block succeeds the edge-clocked receiver: it is fully synchronous, parametrised in timing, payload depth and CRC polynomial, and adds glitch, timeout and unknown-command handling.

Parameters:
CLK_PER_US, 4, clk cycles per microsecond (must be >=4)
MAX_DATA_BYTES, 32, payload bytes for WRITE (cmd 0x03)
IDLE_US, 8, high time mid-frame that aborts the frame
CRC_POLY, 8'h85, data CRC polynomial (MSB-first)

Ports:
clk  in  1  sampling clock
reset  in  1  asynchronous, active-high
tx_busy  in  1  high while our transmitter drives the line; receiver ignores the line and stays in IDLE
data_rx  in  1  raw joybus line (idle high), asynchronous
cmd  out  8  last received command byte
address  out  16  address/addr-CRC field (READ/WRITE)
data_byte  out  8  payload byte
data_valid  out  1  1-cycle strobe, data_byte valid
data_idx  out  clog2(MAX_DATA_BYTES)  index of data_byte
crc  out  8  data CRC of last WRITE
frame_done  out  1  1-cycle pulse, good frame ended
frame_err  out  1  1-cycle pulse, frame aborted
busy  out  1  high from first falling edge until done/err

Behaviour:
- Reset values: cmd=8'hFE, address=0, data_byte=0, data_valid=0, data_idx=0, crc=0, frame_done=0, frame_err=0, busy=0, state=IDLE. Reset mid-frame discards the frame silently; no pulses are generated.
- data_rx passes through a 2-flop synchroniser (reset to 1). Edges are detected on the synchronised value. All latencies below count from the synchronised edge.
- low_cnt counts cycles while the line is low; high_cnt counts cycles while it is high. Both saturate.
- Bit decision at the rising edge: low_cnt < CLK_PER_US/2 is a glitch and gives frame_err. low_cnt < 2*CLK_PER_US gives bit 1. Otherwise bit 0. low_cnt > 4*CLK_PER_US gives frame_err.
- Bits arrive MSB-first. bit_cnt counts decoded bits in the frame.
- States:
  - IDLE: on a falling edge with !tx_busy, set busy and go to LOW.
  - LOW: on a rising edge, decode the bit and go to HIGH.
  - HIGH: on a falling edge go to LOW (or STOP if all expected bits have been received). high_cnt >= IDLE_US*CLK_PER_US gives frame_err and returns to IDLE.
  - STOP: expects the 1 us low stop bit. A rising edge with low_cnt < 2*CLK_PER_US gives frame_done. Any other rising edge gives frame_err. Both return to IDLE.
  - DRAIN: after an unknown command, wait for high_cnt >= IDLE_US*CLK_PER_US, then pulse frame_err and go to IDLE.
- Expected bits: 0x00, 0x01, 0xFF → 8. 0x02 → 24. 0x03 → 24+8*MAX_DATA_BYTES. Any other cmd value → DRAIN once the 8th bit is decoded.
- cmd updates bitwise and is stable from the 8th bit on. address is bits 8..23.
- On each completed payload byte: data_valid pulses 1 cycle after the rising edge of its 8th bit, and data_idx increments (wrapping at MAX_DATA_BYTES).
- CRC: init 0 at the start of each frame; no reflection; fed with payload bits only. After the last payload bit, 8 zero bits are shifted in (augmentation, done in 8 cycles, which is < 1 bit cell). The result is latched into crc before frame_done. Payload of all zeros gives crc=8'h00.
- A falling edge while tx_busy=1 is ignored. tx_busy rising mid-frame aborts the frame with frame_err.
- frame_done and frame_err are mutually exclusive and never occur in the same cycle as a new busy rise.

Decomposition:
- Package n64_joybus_pkg: command codes (CMD_INFO=8'h00, CMD_STATUS=8'h01, CMD_READ=8'h02, CMD_WRITE=8'h03, CMD_RESET=8'hFF), state enum, expected-bit-length function.
- Sub-module n64_crc8_serial: clk, reset, clear, enable, bit_in, rem, with CRC_POLY as a parameter. It is shared with the transmitter.

Test Plan:
- CLK_PER_US=4; send cmd 0x01 plus stop bit → cmd=0x01, frame_done once, busy low afterwards, no data_valid.
- Send READ 0x02, addr 0x8001 → address=16'h8001, frame_done, crc unchanged.
- Send WRITE with 32 bytes 0x00 → 32 data_valid with idx 0..31, crc=0x00. Then bytes 0x00..0x1F → crc equals the bench bit-serial golden model.
- Send cmd 0x42 → DRAIN, then frame_err after 32 high cycles, then cmd 0x00 is accepted normally.
- 1-cycle low glitch mid-byte → frame_err. Line held high 32 cycles mid-READ → frame_err, no frame_done.
- Assert reset during the WRITE payload → all outputs at reset values, no pulses. Next frame (0xFF) → frame_done.
